// File: rtl/robo_controller.sv
// Left-hand wall-following control FSM for a debris-collecting maze robot.
// Optional debris removal is enabled by defining ROBO_REMOVE_EN.
module robo_controller (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic forward,
    output logic turn,
    output logic remove
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_FOLLOW = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_ROTATE = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       fwd_q, fwd_d;
    logic       turn_q, turn_d;
    logic       rem_q, rem_d;
    logic       head_eff;
    logic       bar_eff;

`ifdef ROBO_REMOVE_EN
    assign head_eff = head;
    assign bar_eff  = barrier;
`else
    // Debris is treated as an ordinary wall when removal is not built in.
    assign head_eff = head | barrier;
    assign bar_eff  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fwd_d   = 1'b0;
        turn_d  = 1'b0;
        rem_d   = 1'b0;
        if (under) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_ROTATE: begin
                    if (cnt_q != 2'd0) begin
                        turn_d = 1'b1;
                        cnt_d  = cnt_q - 2'd1;
                        if (cnt_q == 2'd1) state_d = S_FOLLOW;
                    end else begin
                        state_d = S_FOLLOW;
                    end
                end
                S_FOLLOW: begin
                    if (!left) begin
                        turn_d  = 1'b1;
                        state_d = S_STEP;
                    end else if (bar_eff) begin
                        rem_d = 1'b1;
                    end else if (!head_eff) begin
                        fwd_d = 1'b1;
                    end else begin
                        turn_d  = 1'b1;
                        cnt_d   = 2'd2;
                        state_d = S_ROTATE;
                    end
                end
                S_STEP: begin
                    if (bar_eff) begin
                        rem_d = 1'b1;
                    end else if (!head_eff) begin
                        fwd_d   = 1'b1;
                        state_d = S_FOLLOW;
                    end else begin
                        turn_d  = 1'b1;
                        cnt_d   = 2'd2;
                        state_d = S_ROTATE;
                    end
                end
                // IDLE with under low is evaluated exactly like SEARCH.
                default: begin
                    state_d = S_SEARCH;
                    if (bar_eff) begin
                        rem_d = 1'b1;
                    end else if (!head_eff) begin
                        fwd_d = 1'b1;
                        if (left) state_d = S_FOLLOW;
                    end else begin
                        turn_d  = 1'b1;
                        cnt_d   = 2'd2;
                        state_d = S_ROTATE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fwd_q   <= 1'b0;
            turn_q  <= 1'b0;
            rem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
            turn_q  <= turn_d;
            rem_q   <= rem_d;
        end
    end

    assign forward = fwd_q;
    assign turn    = turn_q;
    assign remove  = rem_q;

endmodule

// File: tb/tb_robo_controller.sv
// Self-checking bench for robo_controller: directed plan plus randomized
// sensor stimulus checked against a behavioural model of the robot rules.
module tb_robo_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic head = 1'b0, left = 1'b0, under = 1'b1, barrier = 1'b0;
    logic forward, turn, remove;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what the robot is doing, and how many right-turn quarters remain.
    typedef enum {M_IDLE, M_SEARCH, M_FOLLOW, M_STEP} mode_t;
    mode_t mode = M_IDLE;
    int    pend_turns = 0;
    logic [2:0] exp_act;   // {forward, turn, remove}

`ifdef ROBO_REMOVE_EN
    localparam bit REMOVE_EN = 1'b1;
`else
    localparam bit REMOVE_EN = 1'b0;
`endif

    robo_controller dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .forward (forward),
        .turn    (turn),
        .remove  (remove)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the robot's rules to the sensor values sampled at the coming edge.
    task automatic model_step();
        bit wall, debris;
        wall    = head | (barrier & !REMOVE_EN);
        debris  = barrier & REMOVE_EN;
        exp_act = 3'b000;
        if (reset || under) begin
            mode       = M_IDLE;
            pend_turns = 0;
        end else if (pend_turns > 0) begin
            exp_act = 3'b010;
            pend_turns--;
            if (pend_turns == 0) mode = M_FOLLOW;
        end else begin
            if (mode == M_IDLE) mode = M_SEARCH;
            if (mode == M_FOLLOW && !left) begin
                exp_act = 3'b010;
                mode    = M_STEP;
            end else if (debris) begin
                exp_act = 3'b001;
            end else if (!wall) begin
                exp_act = 3'b100;
                if (mode == M_STEP || (mode == M_SEARCH && left)) mode = M_FOLLOW;
            end else begin
                exp_act    = 3'b010;
                pend_turns = 2;   // two more quarters after this one
            end
        end
    endtask

    task automatic tick(input bit r, input bit u, input bit h, input bit l, input bit b);
        reset = r; under = u; head = h; left = l; barrier = b;
        model_step();
        @(posedge clock);
        #1;
        check_eq("model_act", {forward, turn, remove}, exp_act);
        check_eq("onehot", 32'($countones({forward, turn, remove}) <= 1), 32'd1);
    endtask

    // Directed step with a hand-derived expected action as well.
    task automatic dtick(input string tag, input bit r, input bit u, input bit h,
                         input bit l, input bit b, input logic [2:0] want);
        tick(r, u, h, l, b);
        check_eq(tag, {forward, turn, remove}, want);
    endtask

    initial begin
        @(negedge clock);
        // Reset held with under, then released with under still high.
        dtick("reset_a", 1, 1, 0, 0, 0, 3'b000);
        dtick("reset_b", 1, 1, 0, 0, 0, 3'b000);
        dtick("under_hold", 0, 1, 0, 0, 0, 3'b000);
        dtick("search_fwd", 0, 0, 0, 0, 0, 3'b100);

        // Right turn from SEARCH: three turns, ignoring sensors during rotation.
        dtick("rot_1", 0, 0, 1, 0, 0, 3'b010);
        dtick("rot_2", 0, 0, 1, 0, 1, 3'b010);
        dtick("rot_3", 0, 0, 0, 1, 0, 3'b010);
        dtick("rot_follow", 0, 0, 0, 1, 0, 3'b100);

        // Lose the left wall: one turn, then a forced step.
        dtick("follow_fwd", 0, 0, 0, 1, 0, 3'b100);
        dtick("left_lost", 0, 0, 0, 0, 0, 3'b010);
        dtick("step_fwd", 0, 0, 0, 0, 0, 3'b100);

        // Debris ahead in FOLLOW for three samples.
        if (REMOVE_EN) begin
            dtick("rem_1", 0, 0, 0, 1, 1, 3'b001);
            dtick("rem_2", 0, 0, 1, 1, 1, 3'b001);
            dtick("rem_3", 0, 0, 0, 1, 1, 3'b001);
        end else begin
            dtick("bar_rot_1", 0, 0, 0, 1, 1, 3'b010);
            dtick("bar_rot_2", 0, 0, 1, 1, 1, 3'b010);
            dtick("bar_rot_3", 0, 0, 0, 1, 1, 3'b010);
        end
        dtick("after_bar", 0, 0, 0, 1, 0, 3'b100);

        // under mid-rotation discards pending turns.
        dtick("rot_start", 0, 0, 1, 1, 0, 3'b010);
        dtick("under_rot", 0, 1, 1, 1, 0, 3'b000);
        dtick("under_rot2", 0, 1, 0, 0, 0, 3'b000);
        dtick("restart_1", 0, 0, 0, 0, 0, 3'b100);
        dtick("restart_2", 0, 0, 0, 0, 0, 3'b100);

        // Reset during forward and during debris activity.
        dtick("rst_fwd", 1, 0, 0, 0, 0, 3'b000);
        dtick("bar_act", 0, 0, 0, 0, 1, REMOVE_EN ? 3'b001 : 3'b010);
        dtick("rst_bar", 1, 0, 0, 0, 1, 3'b000);

        // Randomized sensors, occasional reset/under.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(63) == 0, $urandom_range(15) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
